// File: rtl/ppi_bus_master_if.sv
// Request/response and control bundle between the host request logic and the 8255A bus master.
// control = {nCs, nRe, nWr, Reset, A1, A0}; the tristate data bus PD stays a plain port.
interface ppi_bus_master_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       ppi_rst_req;
  logic       done;
  logic [7:0] rsp_rdata;
  logic [5:0] control;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, ppi_rst_req,
    output req_ready, done, rsp_rdata, control
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ppi_rst_req,
    input  req_ready, done, rsp_rdata, control
  );
endinterface

// File: rtl/ppi_bus_master.sv
// 8255A PPI bus initiator: turns single-beat read/write requests and device-reset requests
// into timed SETUP/STROBE/HOLD (or RST) bus phases with registered control outputs.
module ppi_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RESET_CYC  = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             nReset,
  ppi_bus_master_if.master bus,
  inout  wire  [7:0]       PD
);

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC ?
                            (SETUP_CYC > HOLD_CYC ? (SETUP_CYC > RESET_CYC ? SETUP_CYC : RESET_CYC)
                                                  : (HOLD_CYC > RESET_CYC ? HOLD_CYC : RESET_CYC))
                          : (STROBE_CYC > HOLD_CYC ? (STROBE_CYC > RESET_CYC ? STROBE_CYC : RESET_CYC)
                                                   : (HOLD_CYC > RESET_CYC ? HOLD_CYC : RESET_CYC)));

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || RESET_CYC < 1 ||
      (MAX_CYC - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("ppi_bus_master: phase lengths must be >=1 and CNT_W must hold max phase length - 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RST} state_t;

  localparam logic [5:0] CTRL_IDLE = 6'b111000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       control_q, control_d;
  logic             pd_oe_q, pd_oe_d;
  logic             done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             write_q, write_d;
  logic [1:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;

  function automatic logic [5:0] ctrl_for(state_t s, logic wr, logic [1:0] a);
    case (s)
      SETUP, HOLD: return {1'b0, 1'b1, 1'b1, 1'b0, a};
      STROBE:      return {1'b0, wr, ~wr, 1'b0, a};
      RST:         return 6'b111100;
      default:     return CTRL_IDLE;
    endcase
  endfunction

  assign bus.req_ready = (state_q == IDLE) && !bus.ppi_rst_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.ppi_rst_req) begin
          state_d = RST;
          cnt_d   = CNT_W'(RESET_CYC - 1);
        end else if (bus.req_valid) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          // PPI still drives PD here: nRe is low throughout the last strobe cycle
          if (!write_q) rdata_d = PD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD, RST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    control_d = ctrl_for(state_d, write_d, addr_d);
    pd_oe_d   = write_d && (state_d == SETUP || state_d == STROBE || state_d == HOLD);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      control_q <= CTRL_IDLE;
      pd_oe_q   <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      control_q <= control_d;
      pd_oe_q   <= pd_oe_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  // Latched request fields only matter while pd_oe_q/state say so; no reset needed
  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.control   = control_q;
  assign bus.done      = done_q;
  assign bus.rsp_rdata = rdata_q;
  assign PD            = pd_oe_q ? wdata_q : 8'hzz;

  a_strobe_excl: assert property (@(posedge clk) disable iff (!nReset)
    !(!control_q[4] && !control_q[3]));
  a_reset_ncs: assert property (@(posedge clk) disable iff (!nReset)
    control_q[2] |-> control_q[5]);
  a_no_contention: assert property (@(posedge clk) disable iff (!nReset)
    pd_oe_q |-> control_q[4]);

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master: default-timing instance plus a long-phase instance,
// each with a simple PPI model that drives PD only while nRe is low.
module tb_ppi_bus_master;
  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  ppi_bus_master_if bus ();
  ppi_bus_master_if bus2 ();
  wire  [7:0] PD, PD2;
  logic [7:0] ppi_val, ppi_val2;

  assign PD  = (bus.control[4]  == 1'b0) ? ppi_val  : 8'hzz;
  assign PD2 = (bus2.control[4] == 1'b0) ? ppi_val2 : 8'hzz;

  ppi_bus_master dut (.clk(clk), .nReset(nReset), .bus(bus), .PD(PD));

  ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(5), .HOLD_CYC(2), .RESET_CYC(6), .CNT_W(4))
    dut2 (.clk(clk), .nReset(nReset), .bus(bus2), .PD(PD2));

  int checks = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.ppi_rst_req = 0;
    bus2.req_valid = 0; bus2.req_write = 0; bus2.req_addr = 0; bus2.req_wdata = 0; bus2.ppi_rst_req = 0;
    ppi_val = 8'h5A; ppi_val2 = 8'hC9;
    nReset = 0;
    #12;
    checks++; if (bus.control !== 6'h38) begin failures++; $display("FAIL reset_control got=%h exp=38", bus.control); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", bus.rsp_rdata); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    checks++; if (dut.pd_oe_q !== 1'b0) begin failures++; $display("FAIL reset_pd_oe got=%b exp=0", dut.pd_oe_q); end
    @(negedge clk) nReset = 1;
    step();
  endtask

  task automatic test_write();
    logic [5:0] exp_c [5] = '{6'h1B, 6'h13, 6'h13, 6'h1B, 6'h38};
    bus.req_write = 1; bus.req_addr = 2'd3; bus.req_wdata = 8'h80; bus.req_valid = 1;
    step();
    bus.req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++; if (bus.control !== exp_c[i]) begin failures++; $display("FAIL write_control[%0d] got=%h exp=%h", i, bus.control, exp_c[i]); end
      checks++; if (bus.done !== (i == 4)) begin failures++; $display("FAIL write_done[%0d] got=%b exp=%b", i, bus.done, i == 4); end
      if (i < 4) begin
        checks++; if (PD !== 8'h80) begin failures++; $display("FAIL write_pd[%0d] got=%h exp=80", i, PD); end
      end else begin
        checks++; if (dut.pd_oe_q !== 1'b0) begin failures++; $display("FAIL write_pd_release got=%b exp=0", dut.pd_oe_q); end
      end
    end
    step();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL write_done_pulse got=%b exp=0", bus.done); end
  endtask

  task automatic test_read();
    logic [5:0] exp_c [5] = '{6'h18, 6'h08, 6'h08, 6'h18, 6'h38};
    ppi_val = 8'h5A;
    bus.req_write = 0; bus.req_addr = 2'd0; bus.req_wdata = 8'hFF; bus.req_valid = 1;
    step();
    bus.req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++; if (bus.control !== exp_c[i]) begin failures++; $display("FAIL read_control[%0d] got=%h exp=%h", i, bus.control, exp_c[i]); end
      checks++; if (dut.pd_oe_q !== 1'b0) begin failures++; $display("FAIL read_pd_driven[%0d] got=%b exp=0", i, dut.pd_oe_q); end
      checks++; if (bus.done !== (i == 4)) begin failures++; $display("FAIL read_done[%0d] got=%b exp=%b", i, bus.done, i == 4); end
    end
    checks++; if (bus.rsp_rdata !== 8'h5A) begin failures++; $display("FAIL read_rdata got=%h exp=5A", bus.rsp_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_c [10] = '{6'h19, 6'h11, 6'h11, 6'h19, 6'h38, 6'h19, 6'h11, 6'h11, 6'h19, 6'h38};
    bus.req_write = 1; bus.req_addr = 2'd1; bus.req_wdata = 8'h11; bus.req_valid = 1;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      checks++; if (bus.control !== exp_c[i]) begin failures++; $display("FAIL b2b_control[%0d] got=%h exp=%h", i, bus.control, exp_c[i]); end
      checks++; if (bus.done !== (i == 4 || i == 9)) begin failures++; $display("FAIL b2b_done[%0d] got=%b", i, bus.done); end
      if (i < 4) begin
        checks++; if (PD !== 8'h11) begin failures++; $display("FAIL b2b_pd_first[%0d] got=%h exp=11", i, PD); end
      end else if (i > 4 && i < 9) begin
        checks++; if (PD !== 8'h22) begin failures++; $display("FAIL b2b_pd_second[%0d] got=%h exp=22", i, PD); end
      end
      if (i == 4) begin
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_on_done got=%b exp=1", bus.req_ready); end
      end
      if (i == 0) bus.req_wdata = 8'h22;
      if (i == 5) bus.req_valid = 0;
    end
    step();
  endtask

  task automatic test_reset_priority();
    logic [5:0] exp_c [10] = '{6'h3C, 6'h3C, 6'h3C, 6'h3C, 6'h38, 6'h1A, 6'h0A, 6'h0A, 6'h1A, 6'h38};
    ppi_val = 8'hA7;
    bus.req_write = 0; bus.req_addr = 2'd2; bus.req_valid = 1; bus.ppi_rst_req = 1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL prio_ready_blocked got=%b exp=0", bus.req_ready); end
    step();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      checks++; if (bus.control !== exp_c[i]) begin failures++; $display("FAIL prio_control[%0d] got=%h exp=%h", i, bus.control, exp_c[i]); end
      checks++; if (bus.done !== (i == 4 || i == 9)) begin failures++; $display("FAIL prio_done[%0d] got=%b", i, bus.done); end
      if (i < 4) begin
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL prio_ready_rst[%0d] got=%b exp=0", i, bus.req_ready); end
      end
      if (i == 0) bus.ppi_rst_req = 0;
      if (i == 5) bus.req_valid = 0;
    end
    checks++; if (bus.rsp_rdata !== 8'hA7) begin failures++; $display("FAIL prio_rdata got=%h exp=A7", bus.rsp_rdata); end
    step();
  endtask

  task automatic test_abort();
    bit seen_done = 0;
    bus.req_write = 1; bus.req_addr = 2'd0; bus.req_wdata = 8'hC3; bus.req_valid = 1;
    step();
    bus.req_valid = 0;
    step();
    step();
    checks++; if (bus.control !== 6'h10) begin failures++; $display("FAIL abort_pre_control got=%h exp=10", bus.control); end
    #2 nReset = 0;
    #1;
    checks++; if (bus.control !== 6'h38) begin failures++; $display("FAIL abort_control got=%h exp=38", bus.control); end
    checks++; if (dut.pd_oe_q !== 1'b0) begin failures++; $display("FAIL abort_pd_oe got=%b exp=0", dut.pd_oe_q); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    @(negedge clk) nReset = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) seen_done = 1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.rsp_rdata !== 8'h00) begin failures++; $display("FAIL abort_rdata got=%h exp=00", bus.rsp_rdata); end
  endtask

  task automatic test_phase_lengths();
    logic [5:0] e;
    // write addr 2: 3 setup, 5 strobe, 2 hold
    bus2.req_write = 1; bus2.req_addr = 2'd2; bus2.req_wdata = 8'h5C; bus2.req_valid = 1;
    step();
    bus2.req_valid = 0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      e = (i < 3) ? 6'h1A : (i < 8) ? 6'h12 : (i < 10) ? 6'h1A : 6'h38;
      checks++; if (bus2.control !== e) begin failures++; $display("FAIL len_wr_control[%0d] got=%h exp=%h", i, bus2.control, e); end
      checks++; if (bus2.done !== (i == 10)) begin failures++; $display("FAIL len_wr_done[%0d] got=%b", i, bus2.done); end
      if (i < 10) begin
        checks++; if (PD2 !== 8'h5C) begin failures++; $display("FAIL len_wr_pd[%0d] got=%h exp=5C", i, PD2); end
      end
    end
    step();
    // read addr 1
    bus2.req_write = 0; bus2.req_addr = 2'd1; bus2.req_valid = 1;
    step();
    bus2.req_valid = 0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      e = (i < 3) ? 6'h19 : (i < 8) ? 6'h09 : (i < 10) ? 6'h19 : 6'h38;
      checks++; if (bus2.control !== e) begin failures++; $display("FAIL len_rd_control[%0d] got=%h exp=%h", i, bus2.control, e); end
      checks++; if (bus2.done !== (i == 10)) begin failures++; $display("FAIL len_rd_done[%0d] got=%b", i, bus2.done); end
    end
    checks++; if (bus2.rsp_rdata !== 8'hC9) begin failures++; $display("FAIL len_rd_rdata got=%h exp=C9", bus2.rsp_rdata); end
    step();
    // device reset: 6 cycles
    bus2.ppi_rst_req = 1;
    step();
    bus2.ppi_rst_req = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      e = (i < 6) ? 6'h3C : 6'h38;
      checks++; if (bus2.control !== e) begin failures++; $display("FAIL len_rst_control[%0d] got=%h exp=%h", i, bus2.control, e); end
      checks++; if (bus2.done !== (i == 6)) begin failures++; $display("FAIL len_rst_done[%0d] got=%b", i, bus2.done); end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_priority();
    test_abort();
    test_phase_lengths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
